crop_window_ctrl: RTL and testbench
===================================

Name: crop_window_ctrl

Overview:
Control block that owns the crop-window coordinates (start_x, start_y, end_x, end_y) driving the downstream image crop stage.
- Accepts window updates over a valid/ready config interface and range-checks them.
- Holds each accepted update in a one-deep pending slot and commits it only at a frame boundary (vs_i rising edge), so the crop stage never sees a window change mid-frame.
- Can optionally auto-pan the window a fixed step per frame, bouncing at the frame edges.

Parameters:
H_DISP, 12'd1280, active frame width in pixels
V_DISP, 12'd720, active frame height in lines
X_WIDTH, 11, width of x coordinate buses
Y_WIDTH, 11, width of y coordinate buses

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
vs_i  in  1  frame sync from video source, active high
cfg_valid  in  1  config request valid
cfg_ready  out  1  config slot free
cfg_start_x  in  X_WIDTH  requested window left, inclusive
cfg_start_y  in  Y_WIDTH  requested window top, inclusive
cfg_end_x  in  X_WIDTH  requested window right, exclusive
cfg_end_y  in  Y_WIDTH  requested window bottom, exclusive
cfg_err  out  1  one-cycle pulse: request rejected
pan_en  in  1  enable auto-pan (CROP_PAN_EN builds only)
pan_step_x  in  8  horizontal pan step per frame
pan_step_y  in  8  vertical pan step per frame
start_x  out  X_WIDTH  active window left
start_y  out  Y_WIDTH  active window top
end_x  out  X_WIDTH  active window right
end_y  out  Y_WIDTH  active window bottom
commit  out  1  one-cycle pulse: window registers updated

Behaviour:
- Reset values: start_x=0, start_y=0, end_x=H_DISP, end_y=V_DISP (full frame); cfg_ready=1, cfg_err=0, commit=0; pending slot empty; pan directions +x, +y.
- Frame boundary:
  - vs_d is vs_i registered.
  - vs_rise = vs_i & ~vs_d.
  - All window updates occur on the clk edge where vs_rise=1, i.e. outputs change one cycle after vs_i is first sampled high.
- States:
  - IDLE: no pending config.
  - PEND: one accepted config waiting for the frame boundary.
  - IDLE -> PEND on a valid handshake. PEND -> IDLE on vs_rise (commit).
- Handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready = (state==IDLE), registered. It drops the cycle after acceptance and returns high the cycle after commit.
- Validation, checked at the transfer cycle:
  - A request is legal iff cfg_start_x < cfg_end_x <= H_DISP and cfg_start_y < cfg_end_y <= V_DISP.
  - Illegal request: cfg_err pulses for 1 cycle on the next cycle, the request is dropped, the state stays IDLE and cfg_ready stays 1.
  - Comparisons are unsigned, zero-extended to 12 bits.
- Commit:
  - On vs_rise in PEND, output registers load the pending values, commit pulses 1 cycle and pan directions reset to +.
  - On vs_rise in IDLE with pan disabled, outputs are held and commit stays 0.
- Simultaneous events:
  - A transfer in the same cycle as vs_rise in IDLE is accepted but not committed until the next vs_rise.
  - vs_rise while vs_i is held high produces only one event.
- Reset mid-operation: the pending slot is discarded and outputs return to full frame on the next edge.
- Outputs are registers only; no combinational path from cfg_* to start/end outputs.

Optional Feature:
- Macro: CROP_PAN_EN.
- Defined:
  - On vs_rise in IDLE with pan_en=1, the window shifts by pan_step_x/pan_step_y in the current direction. Width and height are preserved.
  - +x: if end_x+step > H_DISP, then end_x=H_DISP, start_x=H_DISP-width, dir_x flips to -. Otherwise both shift by +step.
  - -x: if start_x < step, then start_x=0, end_x=width, dir_x flips to +. Otherwise both shift by -step.
  - y follows the same rules against V_DISP. A step of 0 leaves that axis unchanged.
  - A pending commit has priority over pan on the same vs_rise.
  - commit pulses on every pan update that changes any output.
  - Intermediate sums are 13 bits wide to avoid wrap.
- Not defined: pan_en, pan_step_x and pan_step_y are ignored (ports remain); the window changes only via commit.

Test Plan:
- Reset, then 3 frames with no config -> outputs 0/0/1280/720 throughout, commit never pulses, cfg_ready=1.
- Send cfg 100/50/740/530 mid-frame -> cfg_ready=0 the next cycle, outputs unchanged until vs_rise, then outputs 100/50/740/530, commit pulses 1 cycle, cfg_ready=1 the cycle after.
- Send illegal cfg with start_x=800, end_x=800; then end_x=1281 -> cfg_err pulses once per request, outputs and cfg_ready unchanged.
- Transfer in the same cycle as vs_rise -> no commit that frame; commit at the following vs_rise. A second cfg_valid while in PEND is not accepted.
- CROP_PAN_EN, window 1100/0/1260/100, step_x=40, pan_en=1 -> after frame 1: 1120/0/1280/100 with dir flipped; frame 2: 1080/0/1240/100; frame 3: 1040/0/1200/100.
- Assert rst while in PEND -> next cycle outputs full frame, cfg_ready=1, no commit at the subsequent vs_rise.

Source files
------------

// File: rtl/crop_window_ctrl.sv
// ---------------------------------------------------------------------------
// crop_window_ctrl
//
// Purpose:
//   Owns the crop-window coordinates (start/end x/y) that drive the
//   downstream crop stage. Window updates arrive over a valid/ready config
//   interface, are range-checked, parked in a one-deep pending slot and
//   committed only on the rising edge of the frame sync, so the crop stage
//   never sees a window change in the middle of a frame.
//
// Optional feature (macro CROP_PAN_EN):
//   When defined, the window can auto-pan by a fixed step every frame,
//   bouncing off the frame edges. When undefined, pan_en / pan_step_x /
//   pan_step_y are present on the port list but ignored.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   vs_i                      frame sync from the video source (active high)
//   cfg_valid / cfg_ready     config request handshake
//   cfg_start_x/y, cfg_end_x/y requested window (start inclusive, end exclusive)
//   cfg_err                   one-cycle pulse when a request is rejected
//   pan_en, pan_step_x/y      auto-pan control (CROP_PAN_EN builds only)
//   start_x/y, end_x/y        active window (registered)
//   commit                    one-cycle pulse when the window registers change
// ---------------------------------------------------------------------------
module crop_window_ctrl #(
  parameter logic [11:0] H_DISP  = 12'd1280,
  parameter logic [11:0] V_DISP  = 12'd720,
  parameter int          X_WIDTH = 11,
  parameter int          Y_WIDTH = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vs_i,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [X_WIDTH-1:0] cfg_start_x,
  input  logic [Y_WIDTH-1:0] cfg_start_y,
  input  logic [X_WIDTH-1:0] cfg_end_x,
  input  logic [Y_WIDTH-1:0] cfg_end_y,
  output logic               cfg_err,
  input  logic               pan_en,
  input  logic [7:0]         pan_step_x,
  input  logic [7:0]         pan_step_y,
  output logic [X_WIDTH-1:0] start_x,
  output logic [Y_WIDTH-1:0] start_y,
  output logic [X_WIDTH-1:0] end_x,
  output logic [Y_WIDTH-1:0] end_y,
  output logic               commit
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_vsD;
  logic               w_vsRise;
  logic               r_cfgReady;
  logic               r_cfgErr;
  logic               r_commit;
  logic [X_WIDTH-1:0] r_startX, r_endX, r_pendSx, r_pendEx;
  logic [Y_WIDTH-1:0] r_startY, r_endY, r_pendSy, r_pendEy;
  logic               w_xfer;
  logic               w_legal;
  logic               w_accept;
  logic               w_doCommit;

  // A held-high vs_i yields a single event because only the 0->1 transition counts.
  assign w_vsRise = vs_i & ~r_vsD;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic: a legal handshake parks a config, the next frame boundary commits it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = PEND;
      PEND:    if (w_vsRise) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output/decode logic: handshake, range check (zero-extended to 12 bits), commit strobe.
  always_comb begin
    w_xfer     = cfg_valid & r_cfgReady;
    w_legal    = (12'(cfg_start_x) < 12'(cfg_end_x)) && (12'(cfg_end_x) <= H_DISP) &&
                 (12'(cfg_start_y) < 12'(cfg_end_y)) && (12'(cfg_end_y) <= V_DISP);
    w_accept   = w_xfer & w_legal;
    w_doCommit = w_vsRise & (r_state == PEND);
  end

`ifdef CROP_PAN_EN
  // Pan direction per axis: 0 = positive, 1 = negative.
  logic               r_dirX, r_dirY;
  logic [12:0]        w_sx13, w_ex13, w_wx13, w_stX13, w_nSx13, w_nEx13;
  logic [12:0]        w_sy13, w_ey13, w_wy13, w_stY13, w_nSy13, w_nEy13;
  logic               w_nDirX, w_nDirY;
  logic [X_WIDTH-1:0] w_panSx, w_panEx;
  logic [Y_WIDTH-1:0] w_panSy, w_panEy;
  logic               w_doPan;
  logic               w_panChange;

  // Bounce-pan computation in 13 bits so end+step can never wrap; width/height are preserved.
  always_comb begin
    w_sx13  = 13'(r_startX);
    w_ex13  = 13'(r_endX);
    w_wx13  = w_ex13 - w_sx13;
    w_stX13 = 13'(pan_step_x);
    w_nSx13 = w_sx13;
    w_nEx13 = w_ex13;
    w_nDirX = r_dirX;
    if (!r_dirX) begin
      if (w_ex13 + w_stX13 > 13'(H_DISP)) begin
        w_nEx13 = 13'(H_DISP);
        w_nSx13 = 13'(H_DISP) - w_wx13;
        w_nDirX = 1'b1;
      end else begin
        w_nSx13 = w_sx13 + w_stX13;
        w_nEx13 = w_ex13 + w_stX13;
      end
    end else begin
      if (w_sx13 < w_stX13) begin
        w_nSx13 = 13'd0;
        w_nEx13 = w_wx13;
        w_nDirX = 1'b0;
      end else begin
        w_nSx13 = w_sx13 - w_stX13;
        w_nEx13 = w_ex13 - w_stX13;
      end
    end

    w_sy13  = 13'(r_startY);
    w_ey13  = 13'(r_endY);
    w_wy13  = w_ey13 - w_sy13;
    w_stY13 = 13'(pan_step_y);
    w_nSy13 = w_sy13;
    w_nEy13 = w_ey13;
    w_nDirY = r_dirY;
    if (!r_dirY) begin
      if (w_ey13 + w_stY13 > 13'(V_DISP)) begin
        w_nEy13 = 13'(V_DISP);
        w_nSy13 = 13'(V_DISP) - w_wy13;
        w_nDirY = 1'b1;
      end else begin
        w_nSy13 = w_sy13 + w_stY13;
        w_nEy13 = w_ey13 + w_stY13;
      end
    end else begin
      if (w_sy13 < w_stY13) begin
        w_nSy13 = 13'd0;
        w_nEy13 = w_wy13;
        w_nDirY = 1'b0;
      end else begin
        w_nSy13 = w_sy13 - w_stY13;
        w_nEy13 = w_ey13 - w_stY13;
      end
    end

    w_panSx     = X_WIDTH'(w_nSx13);
    w_panEx     = X_WIDTH'(w_nEx13);
    w_panSy     = Y_WIDTH'(w_nSy13);
    w_panEy     = Y_WIDTH'(w_nEy13);
    w_doPan     = w_vsRise & (r_state == IDLE) & pan_en;
    w_panChange = (w_panSx != r_startX) || (w_panEx != r_endX) ||
                  (w_panSy != r_startY) || (w_panEy != r_endY);
  end
`else
  // Pan controls exist on the port list in every build but do nothing here.
  logic w_unusedPan;
  assign w_unusedPan = ^{pan_en, pan_step_x, pan_step_y};
`endif

  // Datapath registers: pending slot, active window, status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsD      <= 1'b0;
      r_cfgReady <= 1'b1;
      r_cfgErr   <= 1'b0;
      r_commit   <= 1'b0;
      r_startX   <= '0;
      r_startY   <= '0;
      r_endX     <= X_WIDTH'(H_DISP);
      r_endY     <= Y_WIDTH'(V_DISP);
      r_pendSx   <= '0;
      r_pendSy   <= '0;
      r_pendEx   <= '0;
      r_pendEy   <= '0;
`ifdef CROP_PAN_EN
      r_dirX     <= 1'b0;
      r_dirY     <= 1'b0;
`endif
    end else begin
      r_vsD      <= vs_i;
      r_cfgReady <= (w_nextState == IDLE);
      r_cfgErr   <= w_xfer & ~w_legal;
      r_commit   <= 1'b0;
      if (w_accept) begin
        r_pendSx <= cfg_start_x;
        r_pendSy <= cfg_start_y;
        r_pendEx <= cfg_end_x;
        r_pendEy <= cfg_end_y;
      end
      // A pending commit always wins over pan on the same frame boundary.
      if (w_doCommit) begin
        r_startX <= r_pendSx;
        r_startY <= r_pendSy;
        r_endX   <= r_pendEx;
        r_endY   <= r_pendEy;
        r_commit <= 1'b1;
`ifdef CROP_PAN_EN
        r_dirX   <= 1'b0;
        r_dirY   <= 1'b0;
`endif
      end
`ifdef CROP_PAN_EN
      else if (w_doPan) begin
        r_startX <= w_panSx;
        r_startY <= w_panSy;
        r_endX   <= w_panEx;
        r_endY   <= w_panEy;
        r_dirX   <= w_nDirX;
        r_dirY   <= w_nDirY;
        r_commit <= w_panChange;
      end
`endif
    end
  end

  assign cfg_ready = r_cfgReady;
  assign cfg_err   = r_cfgErr;
  assign commit    = r_commit;
  assign start_x   = r_startX;
  assign start_y   = r_startY;
  assign end_x     = r_endX;
  assign end_y     = r_endY;

endmodule

// File: tb/tb_crop_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_crop_window_ctrl
//
// Drives crop_window_ctrl with directed scenarios followed by a randomized
// phase, and compares every output each cycle against a frame-level model
// of the crop window written with plain integer arithmetic. Pan behaviour
// is modelled only when CROP_PAN_EN is defined, matching the DUT build.
// ---------------------------------------------------------------------------
module tb_crop_window_ctrl;

  localparam int HD = 1280;
  localparam int VD = 720;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsI;
  logic        cfgValid;
  logic        cfgReady;
  logic [10:0] cfgSx, cfgSy, cfgEx, cfgEy;
  logic        cfgErr;
  logic        panEn;
  logic [7:0]  stepX, stepY;
  logic [10:0] startX, startY, endX, endY;
  logic        commitO;

  int nAssert = 0;
  int nFail   = 0;

  // Reference model state, expressed as whole-window values.
  int mSx, mSy, mEx, mEy;
  int pSx, pSy, pEx, pEy;
  bit mPend, mReady, mErr, mCommit, mVsPrev;
  int mDirX, mDirY;

  crop_window_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vs_i       (vsI),
    .cfg_valid  (cfgValid),
    .cfg_ready  (cfgReady),
    .cfg_start_x(cfgSx),
    .cfg_start_y(cfgSy),
    .cfg_end_x  (cfgEx),
    .cfg_end_y  (cfgEy),
    .cfg_err    (cfgErr),
    .pan_en     (panEn),
    .pan_step_x (stepX),
    .pan_step_y (stepY),
    .start_x    (startX),
    .start_y    (startY),
    .end_x      (endX),
    .end_y      (endY),
    .commit     (commitO)
  );

  always #5 clk = ~clk;

  // Bounce one axis of the window by step, keeping its size.
  function automatic void panAxis(inout int s, inout int e, inout int dir,
                                  input int step, input int lim);
    int w;
    w = e - s;
    if (dir > 0) begin
      if (e + step > lim) begin e = lim; s = lim - w; dir = -1; end
      else begin s = s + step; e = e + step; end
    end else begin
      if (s < step) begin s = 0; e = w; dir = 1; end
      else begin s = s - step; e = e - step; end
    end
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void modelUpdate();
    bit rise, xfer, legal;
    int oSx, oSy, oEx, oEy;
    if (rst) begin
      mSx = 0; mSy = 0; mEx = HD; mEy = VD;
      mPend = 0; mReady = 1; mErr = 0; mCommit = 0; mVsPrev = 0;
      mDirX = 1; mDirY = 1;
      return;
    end
    rise    = vsI && !mVsPrev;
    mVsPrev = vsI;
    xfer    = cfgValid && mReady;
    legal   = (int'(cfgSx) < int'(cfgEx)) && (int'(cfgEx) <= HD) &&
              (int'(cfgSy) < int'(cfgEy)) && (int'(cfgEy) <= VD);
    mErr    = xfer && !legal;
    mCommit = 0;
    oSx = mSx; oSy = mSy; oEx = mEx; oEy = mEy;
    if (rise && mPend) begin
      mSx = pSx; mSy = pSy; mEx = pEx; mEy = pEy;
      mCommit = 1; mDirX = 1; mDirY = 1; mPend = 0;
    end else if (rise && panEn) begin
`ifdef CROP_PAN_EN
      panAxis(mSx, mEx, mDirX, int'(stepX), HD);
      panAxis(mSy, mEy, mDirY, int'(stepY), VD);
      mCommit = (mSx != oSx) || (mEx != oEx) || (mSy != oSy) || (mEy != oEy);
`endif
    end
    if (xfer && legal) begin
      mPend = 1;
      pSx = int'(cfgSx); pSy = int'(cfgSy); pEx = int'(cfgEx); pEy = int'(cfgEy);
    end
    mReady = !mPend;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkOutput("start_x",   {5'd0, startX},   16'(mSx));
    checkOutput("start_y",   {5'd0, startY},   16'(mSy));
    checkOutput("end_x",     {5'd0, endX},     16'(mEx));
    checkOutput("end_y",     {5'd0, endY},     16'(mEy));
    checkOutput("cfg_ready", {15'd0, cfgReady}, 16'(mReady));
    checkOutput("cfg_err",   {15'd0, cfgErr},   16'(mErr));
    checkOutput("commit",    {15'd0, commitO},  16'(mCommit));
  endtask

  task automatic applyStimulus(input bit vs, input bit valid,
                               input int sx, input int sy, input int ex, input int ey);
    vsI      = vs;
    cfgValid = valid;
    cfgSx    = 11'(sx);
    cfgSy    = 11'(sy);
    cfgEx    = 11'(ex);
    cfgEy    = 11'(ey);
    tick();
  endtask

  task automatic frame(input int lowCycles);
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
    repeat (lowCycles) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    int frameLen;
    int kind;
    int rsx, rsy, rex, rey;

    rst = 1'b1; vsI = 1'b0; cfgValid = 1'b0;
    cfgSx = '0; cfgSy = '0; cfgEx = '0; cfgEy = '0;
    panEn = 1'b0; stepX = '0; stepY = '0;
    $display("[TB] reset");
    tick();
    tick();
    checkOutput("rst_end_x", {5'd0, endX}, 16'd1280);
    checkOutput("rst_end_y", {5'd0, endY}, 16'd720);
    rst = 1'b0;

    $display("[TB] idle frames");
    repeat (3) frame(15);

    $display("[TB] legal config mid-frame");
    applyStimulus(1'b0, 1'b1, 100, 50, 740, 530);
    checkOutput("ready_drop", {15'd0, cfgReady}, 16'd0);
    repeat (4) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
    checkOutput("held_start_x", {5'd0, startX}, 16'd0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
    checkOutput("commit_pulse", {15'd0, commitO}, 16'd1);
    checkOutput("commit_sx", {5'd0, startX}, 16'd100);
    checkOutput("commit_ey", {5'd0, endY}, 16'd530);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
    checkOutput("commit_once", {15'd0, commitO}, 16'd0);
    checkOutput("ready_back", {15'd0, cfgReady}, 16'd1);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);

    $display("[TB] illegal configs");
    applyStimulus(1'b0, 1'b1, 800, 50, 800, 530);
    checkOutput("err_eq", {15'd0, cfgErr}, 16'd1);
    applyStimulus(1'b0, 1'b1, 800, 50, 1281, 530);
    checkOutput("err_wide", {15'd0, cfgErr}, 16'd1);
    applyStimulus(1'b0, 1'b1, 0, 0, 100, 721);
    applyStimulus(1'b0, 1'b1, 10, 600, 20, 500);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
    checkOutput("err_clear", {15'd0, cfgErr}, 16'd0);
    frame(5);

    $display("[TB] transfer on frame boundary, full-frame boundary window");
    applyStimulus(1'b1, 1'b1, 0, 0, 1280, 720);
    checkOutput("no_same_commit", {15'd0, commitO}, 16'd0);
    repeat (3) applyStimulus(1'b1, 1'b1, 5, 5, 50, 50);
    repeat (4) applyStimulus(1'b0, 1'b1, 5, 5, 50, 50);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
    checkOutput("late_commit_ex", {5'd0, endX}, 16'd1280);
    checkOutput("late_commit_sx", {5'd0, startX}, 16'd0);
    frame(4);

    $display("[TB] reset while pending");
    applyStimulus(1'b0, 1'b1, 300, 200, 400, 300);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
    rst = 1'b0;
    checkOutput("rst_pend_ready", {15'd0, cfgReady}, 16'd1);
    frame(4);

`ifdef CROP_PAN_EN
    $display("[TB] auto-pan");
    applyStimulus(1'b0, 1'b1, 1100, 0, 1260, 100);
    frame(4);
    panEn = 1'b1; stepX = 8'd40; stepY = 8'd0;
    repeat (3) frame(4);
    checkOutput("pan_sx", {5'd0, startX}, 16'd1040);
    panEn = 1'b0;
`endif

    $display("[TB] randomized phase");
    frameLen = 23;
    for (int i = 0; i < 2500; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      panEn = $urandom_range(0, 1) == 1;
      stepX = 8'($urandom_range(0, 255));
      stepY = 8'($urandom_range(0, 255));
      kind  = $urandom_range(0, 9);
      rsx = $urandom_range(0, HD - 1);
      rex = $urandom_range(rsx + 1, HD);
      rsy = $urandom_range(0, VD - 1);
      rey = $urandom_range(rsy + 1, VD);
      if (kind == 0) rex = HD + 1;
      else if (kind == 1) rey = VD + 1;
      else if (kind == 2) rex = rsx;
      else if (kind == 3) rey = $urandom_range(0, rsy);
      else if (kind == 4) begin rex = HD; rey = VD; end
      applyStimulus((i % frameLen) < 2, $urandom_range(0, 3) == 0, rsx, rsy, rex, rey);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
